// File: rtl/cpu_bus_arbiter_if.sv
// cpu_bus_arbiter_if: instruction/data requester ports and the shared system bus port of the arbiter
interface cpu_bus_arbiter_if;
  logic        i_inst_request;
  logic [31:0] i_inst_address;
  logic        o_inst_ready;
  logic [31:0] o_inst_rdata;
  logic        i_data_request;
  logic        i_data_rw;
  logic [31:0] i_data_address;
  logic [31:0] i_data_wdata;
  logic        o_data_ready;
  logic [31:0] o_data_rdata;
  logic        o_bus_request;
  logic        o_bus_rw;
  logic [31:0] o_bus_address;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;
  logic        o_busy;
  modport master (
    input  i_inst_request, i_inst_address, i_data_request, i_data_rw, i_data_address, i_data_wdata,
    input  i_bus_ready, i_bus_rdata,
    output o_inst_ready, o_inst_rdata, o_data_ready, o_data_rdata,
    output o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_busy
  );
  modport slave (
    output i_inst_request, i_inst_address, i_data_request, i_data_rw, i_data_address, i_data_wdata,
    output i_bus_ready, i_bus_rdata,
    input  o_inst_ready, o_inst_rdata, o_data_ready, o_data_rdata,
    input  o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_busy
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares the memory bus between instruction and data sides with fixed priority and a starvation limit
module cpu_bus_arbiter #(
  parameter bit DATA_PRIORITY = 1'b1,
  parameter int STARVE_LIMIT  = 4
) (
  input logic               i_clock,
  input logic               i_reset,
  cpu_bus_arbiter_if.master bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pri_req, oth_req, starve, gi, gd;
  state_t        pri_st, oth_st;
  assign pri_req = DATA_PRIORITY ? bus.i_data_request : bus.i_inst_request;
  assign oth_req = DATA_PRIORITY ? bus.i_inst_request : bus.i_data_request;
  assign pri_st  = DATA_PRIORITY ? GRANT_D : GRANT_I;
  assign oth_st  = DATA_PRIORITY ? GRANT_I : GRANT_D;
  assign starve  = cnt_q == CW'(STARVE_LIMIT);
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  // the counter only counts contended priority wins, so it never passes the limit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (pri_req && oth_req) begin
        state_d = starve ? oth_st : pri_st;
        cnt_d   = starve ? '0 : cnt_q + CW'(1);
      end else if (pri_req) state_d = pri_st;
      else if (oth_req) state_d = oth_st;
    end else if (bus.i_bus_ready) state_d = IDLE;
  end
  assign gi = state_q == GRANT_I;
  assign gd = state_q == GRANT_D;
  assign bus.o_bus_request = gi | gd;
  assign bus.o_busy        = gi | gd;
  assign bus.o_bus_rw      = gd & bus.i_data_rw;
  assign bus.o_bus_address = gi ? bus.i_inst_address : gd ? bus.i_data_address : '0;
  assign bus.o_bus_wdata   = gd ? bus.i_data_wdata : '0;
  assign bus.o_inst_ready  = gi & bus.i_bus_ready;
  assign bus.o_data_ready  = gd & bus.i_bus_ready;
  assign bus.o_inst_rdata  = bus.o_inst_ready ? bus.i_bus_rdata : '0;
  assign bus.o_data_rdata  = bus.o_data_ready ? bus.i_bus_rdata : '0;
endmodule
